// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between fetch and the
// memory controller's instruction port; hits return in one cycle, misses issue one load.
module icache #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   input  logic        flush,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic        mc_req,
   output logic [31:0] mc_addr,
   input  logic        mc_received,
   input  logic        mc_done,
   input  logic [31:0] mc_data
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t r_state;
   state_t w_nextState;

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [31:0]       r_data [LINES];

   logic              r_ifValid;
   logic [31:0]       r_ifInst;
   logic              r_mcReq;
   logic [31:0]       r_mcAddr;
   logic              r_discard;

   logic [INDEX_BITS-1:0] w_idx;
   logic [INDEX_BITS-1:0] w_fillIdx;
   logic [TAG_W-1:0]      w_tag;
   logic [TAG_W-1:0]      w_fillTag;
   logic                  w_hit;
   logic                  w_accept;
   logic                  w_fill;
   logic                  w_ifValidNext;
   logic [31:0]           w_ifInstNext;
   logic                  w_mcReqNext;
   logic [31:0]           w_mcAddrNext;
   logic                  w_discardNext;
   logic                  w_unusedPcBits;

   assign w_idx          = if_pc[INDEX_BITS+1:2];
   assign w_tag          = if_pc[31:INDEX_BITS+2];
   // The miss address register doubles as the latched pc for the line fill.
   assign w_fillIdx      = r_mcAddr[INDEX_BITS+1:2];
   assign w_fillTag      = r_mcAddr[31:INDEX_BITS+2];
   assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_accept       = (r_state == IDLE) && if_req && !flush;
   assign w_unusedPcBits = ^if_pc[1:0];

   assign if_valid = r_ifValid;
   assign if_inst  = r_ifInst;
   assign mc_req   = r_mcReq;
   assign mc_addr  = r_mcAddr;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= IDLE;
      end else if (rdy_in) begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept && !w_hit) w_nextState = REQ;
         REQ:     if (mc_received)        w_nextState = WAIT;
         WAIT:    if (mc_done)            w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // A flush only suppresses delivery; the controller transaction always runs to the end.
   always_comb begin
      w_ifValidNext = 1'b0;
      w_ifInstNext  = r_ifInst;
      w_mcReqNext   = r_mcReq;
      w_mcAddrNext  = r_mcAddr;
      w_discardNext = r_discard;
      w_fill        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_hit) begin
                  w_ifValidNext = 1'b1;
                  w_ifInstNext  = r_data[w_idx];
               end else begin
                  w_mcReqNext  = 1'b1;
                  w_mcAddrNext = {if_pc[31:2], 2'b00};
               end
            end
         end
         REQ: begin
            if (flush) w_discardNext = 1'b1;
            if (mc_received) w_mcReqNext = 1'b0;
         end
         WAIT: begin
            if (flush) w_discardNext = 1'b1;
            if (mc_done) begin
               w_fill        = 1'b1;
               w_discardNext = 1'b0;
               if (!r_discard && !flush) begin
                  w_ifValidNext = 1'b1;
                  w_ifInstNext  = mc_data;
               end
            end
         end
         default: begin
            w_mcReqNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_ifValid <= 1'b0;
         r_ifInst  <= 32'h0;
         r_mcReq   <= 1'b0;
         r_mcAddr  <= 32'h0;
         r_discard <= 1'b0;
         r_valid   <= '0;
      end else if (rdy_in) begin
         r_ifValid <= w_ifValidNext;
         r_ifInst  <= w_ifInstNext;
         r_mcReq   <= w_mcReqNext;
         r_mcAddr  <= w_mcAddrNext;
         r_discard <= w_discardNext;
         if (w_fill) r_valid[w_fillIdx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rdy_in && w_fill) begin
         r_tag[w_fillIdx]  <= w_fillTag;
         r_data[w_fillIdx] <= mc_data;
      end
   end

endmodule
